// File: rtl/fp16_vec_accum.sv
`default_nettype none
// ============================================================================
// Module      : fp16_vec_accum
// Description : Four-lane FP16 accumulator. Sums the FP16 product vector from
//               the FP8 multiplier lane-by-lane over a group of beats; a beat
//               flagged in_last closes the group and the lane sums are
//               presented on a registered valid/ready output.
//               Build option: define FP16_ACC_SAT_EN to saturate on overflow
//               to signed max finite; otherwise overflow gives signed infinity.
// Revision    : 1.0 - initial release
// ============================================================================
module fp16_vec_accum (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_vec,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] acc_vec,
    output logic [7:0]  beat_cnt
);

    localparam int          LANES     = 4;
    localparam logic [14:0] MAX_FIN   = 15'h7BFF;
    localparam logic [14:0] INF_MAG   = 15'h7C00;
    localparam logic [4:0]  EXP_SPEC  = 5'h1F;

    // Truncating FP16 add: subnormals flushed, inf/NaN inputs read as max finite.
    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic              sa, sb, sl, ss;
        logic [4:0]        ea, eb, el, es, diff;
        logic [10:0]       ma, mb, ml, ms, ms_sh;
        logic [11:0]       sum;
        logic [3:0]        pos, lz;
        logic signed [6:0] e_res;
        logic [9:0]        mant;
        logic [15:0]       res;
        sa = a[15];
        sb = b[15];
        ea = a[14:10];
        eb = b[14:10];
        ma = (ea == 5'd0) ? 11'd0 : {1'b1, a[9:0]};
        mb = (eb == 5'd0) ? 11'd0 : {1'b1, b[9:0]};
        if (ea == EXP_SPEC) begin
            ea = 5'd30;
            ma = 11'h7FF;
        end
        if (eb == EXP_SPEC) begin
            eb = 5'd30;
            mb = 11'h7FF;
        end
        // Order operands by magnitude; a flushed zero has exp 0 and mant 0.
        if ({ea, ma} >= {eb, mb}) begin
            sl = sa; el = ea; ml = ma;
            ss = sb; es = eb; ms = mb;
        end else begin
            sl = sb; el = eb; ml = mb;
            ss = sa; es = ea; ms = ma;
        end
        diff  = el - es;
        ms_sh = ms >> diff;
        if (sl == ss)
            sum = {1'b0, ml} + {1'b0, ms_sh};
        else
            sum = {1'b0, ml} - {1'b0, ms_sh};
        // Position of the leading one within the 11-bit field.
        pos = 4'd0;
        for (int k = 0; k < 11; k++) begin
            if (sum[k])
                pos = k[3:0];
        end
        lz = 4'd10 - pos;
        if (sum[11]) begin
            e_res = $signed({2'b00, el}) + 7'sd1;
            mant  = sum[10:1];
        end else begin
            e_res = $signed({2'b00, el}) - $signed({3'b000, lz});
            mant  = sum[9:0] << lz;
        end
        if (sum == 12'd0 || e_res <= 7'sd0) begin
            res = 16'h0000;
        end else if (e_res >= 7'sd31) begin
`ifdef FP16_ACC_SAT_EN
            res = {sl, MAX_FIN};
`else
            res = {sl, INF_MAG};
`endif
        end else begin
            res = {sl, e_res[4:0], mant};
        end
        return res;
    endfunction

    logic [LANES-1:0][15:0] acc_q;
    logic [LANES-1:0][15:0] acc_d;
    logic [7:0]             cnt_q;
    logic [7:0]             cnt_d;
    logic                   out_valid_q;
    logic [63:0]            acc_vec_q;
    logic [7:0]             beat_cnt_q;
    logic                   w_accept;

    assign in_ready  = !out_valid_q || out_ready;
    assign w_accept  = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign acc_vec   = acc_vec_q;
    assign beat_cnt  = beat_cnt_q;

    // Saturating running beat count including the current beat.
    assign cnt_d = (cnt_q == 8'hFF) ? 8'hFF : cnt_q + 8'd1;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
`ifdef FP16_ACC_SAT_EN
        assign acc_d[gi] = fp16_add(acc_q[gi], in_vec[16*gi +: 16]);
`else
        // An overflowed lane holds infinity until the group closes.
        assign acc_d[gi] = (acc_q[gi][14:10] == EXP_SPEC) ? acc_q[gi]
                                                           : fp16_add(acc_q[gi], in_vec[16*gi +: 16]);
`endif
    end

    // Accumulate accepted beats; on a closing beat publish the sums and restart.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q       <= '0;
            cnt_q       <= 8'd0;
            out_valid_q <= 1'b0;
            acc_vec_q   <= 64'd0;
            beat_cnt_q  <= 8'd0;
        end else begin
            if (w_accept) begin
                if (in_last) begin
                    acc_vec_q  <= acc_d;
                    beat_cnt_q <= cnt_d;
                    acc_q      <= '0;
                    cnt_q      <= 8'd0;
                end else begin
                    acc_q      <= acc_d;
                    cnt_q      <= cnt_d;
                end
            end
            if (w_accept && in_last)
                out_valid_q <= 1'b1;
            else if (out_ready)
                out_valid_q <= 1'b0;
        end
    end

endmodule
`default_nettype wire
